imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the decode stage. Decodes the

---
 rtl/imm_gen_pipe.sv | 155 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Purpose: decode-stage immediate generator. It decodes the format from the opcode, builds the
//          XLEN immediate and registers it together with the sideband tag behind a valid/ready pair.
// Latency: 1 cycle. An entry accepted at edge N is driven on the outputs after edge N.
// Backpressure: with SKID=1 a two-entry skid buffer keeps full throughput, and in_ready_o comes
//          from registered state only. With SKID=0 there is a single entry and in_ready_o = !out_valid_o | out_ready_i.
// Ports: clk_i/rst_n_i (async active-low), flush_i, in_valid_i/in_ready_o/inst_i/tag_i,
//        out_valid_o/out_ready_i/imm_o/fmt_o/tag_o (fmt: 0=R 1=I 2=S 3=B 4=U 5=J 7=unknown).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skd_q, skd_d;
  entry_t dec;

  logic [31:0] imm32;
  logic        accept;
  logic        pop;

  // ---------------- decode ----------------
  always_comb begin
    imm32   = '0;
    dec     = '0;
    dec.fmt = 3'd7;
    dec.tag = tag_i;
    unique case (inst_i[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.fmt = 3'd4;
        imm32   = {inst_i[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = 3'd5;
        imm32   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
        dec.fmt = 3'd1;
        imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_STORE: begin
        dec.fmt = 3'd2;
        imm32   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = 3'd3;
        imm32   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OP_REG: begin
        dec.fmt = 3'd0;
      end
      default: ;
    endcase
    // Sign-extend the 32-bit result to XLEN. Filling every bit first avoids a zero-width replication when XLEN == 32.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    // For slli/srli/srai the immediate is only the shift amount, zero-extended. The funct7 bits are excluded.
    if (inst_i[6:0] == OP_IMM && inst_i[13:12] == 2'b01) begin
      dec.imm      = '0;
      dec.imm[4:0] = inst_i[24:20];
      if (XLEN == 64) dec.imm[5] = inst_i[25];
    end
  end

  // ---------------- handshake / occupancy ----------------
  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = (SKID != 0) ? (state_q != ST_TWO)
                                   : (state_q == ST_EMPTY) | out_ready_i;
  // An input offered during a flush is discarded even when in_ready_o is high.
  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          out_d = dec;
        end else if (accept) begin
          // Only reachable with SKID=1. With SKID=0, an accept in ONE implies a pop in the same cycle.
          skd_d   = dec;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          out_d   = skd_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skd_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skd_q   <= skd_d;
    end
  end

  assign imm_o = out_q.imm;
  assign fmt_o = out_q.fmt;
  assign tag_o = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] inst;
  logic [4:0]  tag;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [4:0]  tag32;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [4:0]  tag64;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) u_dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .imm_o(imm32), .fmt_o(fmt32), .tag_o(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(0)) u_dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64), .inst_i(inst), .tag_i(tag),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64),
    .imm_o(imm64), .fmt_o(fmt64), .tag_o(tag64)
  );

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: instruction, expected imm at XLEN=32 and 64, expected fmt
  logic [31:0] v_inst [10] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                               32'h004000EF, 32'h4030D093, 32'h0000007F, 32'h02109093,
                               32'h002081B3, 32'h800000B7};
  logic [31:0] v_e32  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                               32'h00000004, 32'h00000003, 32'h00000000, 32'h00000001,
                               32'h00000000, 32'h80000000};
  logic [63:0] v_e64  [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                               64'h0000000012345000, 64'h4, 64'h3, 64'h0, 64'd33, 64'h0,
                               64'hFFFFFFFF80000000};
  logic [2:0]  v_fmt  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd7, 3'd1, 3'd0, 3'd4};

  initial begin
    rst_n = 1'b0; flush = 1'b0; inst = '0; tag = '0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0;
    tick(); tick();
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_imm", {32'd0, imm32}, 64'd0);
    check_val("rst_fmt", {61'd0, fmt32}, 64'd0);
    check_val("rst_tag", {59'd0, tag32}, 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single instructions, one per two cycles, into both instances
    for (int i = 0; i < 10; i++) begin
      inst = v_inst[i]; tag = 5'(i + 3);
      in_valid = 1'b1; in_valid64 = 1'b1; out_ready = 1'b1; out_ready64 = 1'b1;
      tick();
      in_valid = 1'b0; in_valid64 = 1'b0;
      check_val($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check_val($sformatf("vec%0d_imm32", i), {32'd0, imm32}, {32'd0, v_e32[i]});
      check_val($sformatf("vec%0d_fmt32", i), {61'd0, fmt32}, {61'd0, v_fmt[i]});
      check_val($sformatf("vec%0d_tag32", i), {59'd0, tag32}, 64'(i + 3));
      check_val($sformatf("vec%0d_imm64", i), imm64, v_e64[i]);
      check_val($sformatf("vec%0d_fmt64", i), {61'd0, fmt64}, {61'd0, v_fmt[i]});
      tick();
    end
    check_val("drain_valid", {63'd0, out_valid}, 64'd0);

    // Skid: A,B accepted under backpressure, C held, then all three drain in order
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00100093; tag = 5'd1;
    tick();
    check_val("skid_rdy_one", {63'd0, in_ready}, 64'd1);
    inst = 32'h00200093; tag = 5'd2;
    tick();
    check_val("skid_rdy_two", {63'd0, in_ready}, 64'd0);
    check_val("skid_head_A", {32'd0, imm32}, 64'd1);
    inst = 32'h00300093; tag = 5'd3;
    tick();
    check_val("skid_hold_rdy", {63'd0, in_ready}, 64'd0);
    check_val("skid_hold_A", {32'd0, imm32}, 64'd1);
    check_val("skid_hold_tag", {59'd0, tag32}, 64'd1);
    out_ready = 1'b1;
    tick();
    check_val("skid_out_B", {32'd0, imm32}, 64'd2);
    check_val("skid_tag_B", {59'd0, tag32}, 64'd2);
    check_val("skid_rdy_after_pop", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check_val("skid_out_C", {32'd0, imm32}, 64'd3);
    check_val("skid_tag_C", {59'd0, tag32}, 64'd3);
    check_val("skid_valid_C", {63'd0, out_valid}, 64'd1);
    tick();
    check_val("skid_empty", {63'd0, out_valid}, 64'd0);

    // Flush with two entries held and a new entry offered
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00100093; tag = 5'd1;
    tick();
    inst = 32'h00200093; tag = 5'd2;
    tick();
    check_val("flush_pre_full", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; inst = 32'h00700093; tag = 5'd7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_valid", {63'd0, out_valid}, 64'd0);
    check_val("flush_rdy", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick(); tick();
    check_val("flush_no_ghost", {63'd0, out_valid}, 64'd0);
    // Flush in a cycle where only in_ready is high: the offered entry must vanish
    in_valid = 1'b1; flush = 1'b1; inst = 32'h00500093;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_in_drop", {63'd0, out_valid}, 64'd0);

    // SKID=0 single entry: ready follows consumer, pop+accept in one cycle
    out_ready64 = 1'b0; in_valid64 = 1'b1; inst = 32'hFFF00093; tag = 5'd9;
    tick();
    check_val("s0_rdy_full", {63'd0, in_ready64}, 64'd0);
    check_val("s0_imm_A", imm64, 64'hFFFFFFFFFFFFFFFF);
    inst = 32'h02109093; tag = 5'd10;
    tick();
    check_val("s0_hold_A", imm64, 64'hFFFFFFFFFFFFFFFF);
    check_val("s0_hold_tag", {59'd0, tag64}, 64'd9);
    out_ready64 = 1'b1;
    #1;
    check_val("s0_rdy_comb", {63'd0, in_ready64}, 64'd1);
    tick();
    in_valid64 = 1'b0;
    check_val("s0_imm_B", imm64, 64'd33);
    check_val("s0_tag_B", {59'd0, tag64}, 64'd10);
    tick();
    check_val("s0_empty", {63'd0, out_valid64}, 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00100093; tag = 5'd4;
    tick();
    in_valid = 1'b0;
    check_val("ar_loaded", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("ar_valid", {63'd0, out_valid}, 64'd0);
    check_val("ar_imm", {32'd0, imm32}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("ar_still_empty", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
